// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, PC step and fetch state encoding.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, ERR} fetch_state_e;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory request/response handshake.
interface fetch_unit_if import riscv_pkg::*; ();
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_ready, imem_rvalid, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_unit_pc_next.sv
// pc_next: sequential/target PC arithmetic and next-PC selection.
module pc_next import riscv_pkg::*; (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            pc_src_i,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] pc_target_o,
  output logic [XLEN-1:0] pc_next_o,
  output logic            target_misalign_o
);
  assign pc_plus4_o        = pc_i + PC_STEP;
  assign pc_target_o       = pc_i + imm_i;
  assign pc_next_o         = pc_src_i ? pc_target_o : pc_plus4_o;
  assign target_misalign_o = pc_target_o[1:0] != 2'b00;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register and one-at-a-time instruction fetch FSM.
module fetch_unit import riscv_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 64
) (
  input  logic            clk,
  input  logic            reset,
  fetch_unit_if.master    imem,
  input  logic            advance,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] ImmExt,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] pc_target,
  output logic            misalign,
  output logic            timeout
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, instr_q, instr_d, pc_sel;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            misalign_q, misalign_d, timeout_q, timeout_d, tgt_mis;
  pc_next u_pc_next (
    .pc_i(pc_q), .imm_i(ImmExt), .pc_src_i(PCSrc),
    .pc_plus4_o(pc_plus4), .pc_target_o(pc_target), .pc_next_o(pc_sel),
    .target_misalign_o(tgt_mis)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end
  // rvalid is tested before the limit so a response on the last WAIT cycle wins
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    cnt_d      = cnt_q;
    misalign_d = misalign_q;
    timeout_d  = timeout_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: if (imem.imem_ready) begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: if (imem.imem_rvalid) begin
        instr_d = imem.imem_rdata;
        state_d = HOLD;
      end else if (cnt_q == LIMIT) begin
        state_d   = ERR;
        timeout_d = 1'b1;
      end else cnt_d = cnt_q + CW'(1);
      HOLD: if (advance) begin
        if (PCSrc && tgt_mis) begin
          state_d    = ERR;
          misalign_d = 1'b1;
        end else begin
          pc_d    = pc_sel;
          state_d = REQ;
        end
      end
      default: state_d = state_q;
    endcase
  end
  always_comb begin
    imem.imem_req = state_q == REQ;
    instr_valid   = state_q == HOLD;
  end
  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign instr          = instr_q;
  assign misalign       = misalign_q;
  assign timeout        = timeout_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scenario tasks with a scoreboard of expected instruction words.
module tb_fetch_unit;
  import riscv_pkg::*;
  logic        clk = 0, reset = 1, advance = 0, PCSrc = 0;
  logic [31:0] ImmExt = '0;
  logic [31:0] instr, pc, pc_plus4, pc_target;
  logic        instr_valid, misalign, timeout;
  int          errors = 0, checks = 0;
  logic [31:0] sb[$];
  fetch_unit_if bus();
  fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .imem(bus), .advance(advance), .PCSrc(PCSrc), .ImmExt(ImmExt),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .pc_target(pc_target), .misalign(misalign), .timeout(timeout)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic apply_reset();
    reset = 1;
    cyc();
    sb.delete();
    reset = 0;
    cyc();
  endtask
  task automatic step(input logic src, input logic [31:0] imm);
    PCSrc = src;
    ImmExt = imm;
    advance = 1;
    cyc();
    advance = 0;
    PCSrc = 0;
    ImmExt = '0;
  endtask
  // Expects REQ; accepts after rdy_wait cycles and answers on WAIT cycle rv_wait+1.
  task automatic do_fetch(input int rdy_wait, input int rv_wait, output logic [31:0] addr,
                          output int lat, output logic [31:0] got, output logic [31:0] exp,
                          output logic ok);
    addr = bus.imem_addr;
    repeat (rdy_wait) cyc();
    bus.imem_ready = 1;
    cyc();
    bus.imem_ready = 0;
    sb.push_back(mem(addr));
    lat = 1;
    ok = 0;
    got = '0;
    exp = '0;
    while (lat < 20 && !instr_valid) begin
      if (lat - 1 == rv_wait) begin
        bus.imem_rvalid = 1;
        bus.imem_rdata = mem(addr);
      end
      cyc();
      bus.imem_rvalid = 0;
      bus.imem_rdata = '0;
      lat++;
    end
    if (instr_valid) begin
      ok = 1;
      got = instr;
      exp = sb.pop_front();
    end
  endtask

  task automatic test_reset();
    reset = 1;
    cyc();
    cyc();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    checks++; if ({misalign, timeout} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {misalign, timeout}); end
    reset = 0;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b want 0", bus.imem_req); end
    cyc();
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", bus.imem_req); end
  endtask

  task automatic test_sequential();
    logic [31:0] a, g, e;
    int l;
    logic ok;
    for (int i = 0; i < 3; i++) begin
      do_fetch(0, 0, a, l, g, e, ok);
      checks++; if (a !== 32'(i * 4)) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", i, a, 32'(i * 4)); end
      checks++; if (l !== 2) begin errors++; $display("FAIL seq_latency%0d: got %0d want 2", i, l); end
      checks++; if (!ok || g !== e) begin errors++; $display("FAIL seq_instr%0d: got %h valid=%b want %h", i, g, ok, e); end
      step(0, '0);
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL seq_req%0d: got %b want 1", i, bus.imem_req); end
    end
  endtask

  task automatic test_branch();
    logic [31:0] a, g, e;
    int l;
    logic ok;
    do_fetch(0, 0, a, l, g, e, ok);
    checks++; if (a !== 32'h0C) begin errors++; $display("FAIL br_pre_addr: got %h want 0000000c", a); end
    step(1, 32'h0000_00F4);
    do_fetch(0, 0, a, l, g, e, ok);
    checks++; if (a !== 32'h100 || !ok || g !== e) begin errors++; $display("FAIL br_jump: addr %h instr %h want addr 00000100 instr %h", a, g, e); end
    ImmExt = 32'hFFFF_FFF0;
    #1;
    checks++; if (pc_target !== 32'hF0) begin errors++; $display("FAIL br_target: got %h want 000000f0", pc_target); end
    checks++; if (pc_plus4 !== 32'h104) begin errors++; $display("FAIL br_plus4: got %h want 00000104", pc_plus4); end
    step(1, 32'hFFFF_FFF0);
    checks++; if (bus.imem_addr !== 32'hF0 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL br_taken: addr %h req %b want 000000f0 1", bus.imem_addr, bus.imem_req); end
  endtask

  task automatic test_misalign();
    logic [31:0] a, g, e;
    int l;
    logic ok;
    do_fetch(0, 0, a, l, g, e, ok);
    step(1, 32'hFFFF_FF30);
    do_fetch(0, 0, a, l, g, e, ok);
    checks++; if (a !== 32'h20 || !ok) begin errors++; $display("FAIL mis_pre: addr %h valid %b want 00000020 1", a, ok); end
    step(1, 32'h6);
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b want 1", misalign); end
    for (int i = 0; i < 4; i++) begin
      advance = 1;
      bus.imem_ready = 1;
      cyc();
      checks++; if (bus.imem_req !== 1'b0 || pc !== 32'h20 || misalign !== 1'b1 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL mis_hold%0d: req %b pc %h mis %b valid %b want 0 00000020 1 0", i, bus.imem_req, pc, misalign, instr_valid);
      end
    end
    advance = 0;
    bus.imem_ready = 0;
    apply_reset();
    checks++; if (misalign !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL mis_clear: mis %b pc %h want 0 00000000", misalign, pc); end
  endtask

  task automatic test_timeout();
    logic [31:0] a, g, e;
    int l;
    logic ok;
    bus.imem_ready = 1;
    cyc();
    bus.imem_ready = 0;
    repeat (3) cyc();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_early: got %b want 0", timeout); end
    cyc();
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b want 1", timeout); end
    repeat (2) cyc();
    checks++; if (timeout !== 1'b1 || bus.imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL to_sticky: to %b req %b valid %b want 1 0 0", timeout, bus.imem_req, instr_valid);
    end
    apply_reset();
    do_fetch(0, 3, a, l, g, e, ok);
    checks++; if (l !== 5 || !ok || g !== e) begin errors++; $display("FAIL to_last: lat %0d instr %h want 5 %h", l, g, e); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_noerr: got %b want 0", timeout); end
    step(0, '0);
  endtask

  task automatic test_backpressure();
    logic [31:0] a, g, e, a0;
    int l;
    logic ok;
    a0 = bus.imem_addr;
    for (int i = 0; i < 3; i++) begin
      advance = (i == 0);
      PCSrc = (i == 0);
      ImmExt = 32'h40;
      bus.imem_rvalid = (i == 1);
      bus.imem_rdata = 32'hDEAD_BEEF;
      cyc();
      advance = 0;
      PCSrc = 0;
      ImmExt = '0;
      bus.imem_rvalid = 0;
      bus.imem_rdata = '0;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== a0 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: req %b addr %h valid %b want 1 %h 0", i, bus.imem_req, bus.imem_addr, instr_valid, a0);
      end
    end
    do_fetch(0, 0, a, l, g, e, ok);
    checks++; if (a !== 32'h4 || !ok || g !== e) begin errors++; $display("FAIL bp_fetch: addr %h instr %h want 00000004 %h", a, g, e); end
    step(0, '0);
    do_fetch(2, 1, a, l, g, e, ok);
    checks++; if (a !== 32'h8 || l !== 3 || !ok || g !== e) begin errors++; $display("FAIL bp_delay: addr %h lat %0d instr %h want 00000008 3 %h", a, l, g, e); end
    step(0, '0);
  endtask

  task automatic test_reset_wait_wrap();
    logic [31:0] a, g, e;
    int l;
    logic ok;
    bus.imem_ready = 1;
    cyc();
    bus.imem_ready = 0;
    reset = 1;
    cyc();
    reset = 0;
    sb.delete();
    checks++; if (pc !== 32'h0 || bus.imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL rw_idle: pc %h req %b valid %b want 00000000 0 0", pc, bus.imem_req, instr_valid);
    end
    cyc();
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rw_req: got %b want 1", bus.imem_req); end
    do_fetch(0, 0, a, l, g, e, ok);
    step(1, 32'hFFFF_FFFC);
    checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_jump: got %h want fffffffc", bus.imem_addr); end
    do_fetch(0, 0, a, l, g, e, ok);
    checks++; if (pc_plus4 !== 32'h0 || !ok || g !== e) begin errors++; $display("FAIL wrap_plus4: got %h instr %h want 00000000 %h", pc_plus4, g, e); end
    step(0, '0);
    checks++; if (pc !== 32'h0 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL wrap_pc: pc %h req %b want 00000000 1", pc, bus.imem_req); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.imem_ready = 0;
    bus.imem_rvalid = 0;
    bus.imem_rdata = '0;
    test_reset();
    test_sequential();
    test_branch();
    test_misalign();
    test_timeout();
    test_backpressure();
    test_reset_wait_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
